// File: rtl/nios_processor_switches_in.sv
// Avalon-MM input PIO: synchronised (optionally debounced) switch inputs, sticky edge capture, level IRQ.
// Optional debounce filter enabled by macro SWITCHES_IN_DEBOUNCE_EN.
module nios_processor_switches_in #(
  parameter int unsigned WIDTH           = 18,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned EDGE_TYPE       = 0,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // Elaboration-time parameter legality checks
  if (EDGE_TYPE > 2) begin : g_bad_edge_type
    $error("nios_processor_switches_in: EDGE_TYPE %0d is illegal (0..2)", EDGE_TYPE);
  end
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("nios_processor_switches_in: WIDTH %0d out of range (1..32)", WIDTH);
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("nios_processor_switches_in: SYNC_STAGES %0d must be >= 2", SYNC_STAGES);
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("nios_processor_switches_in: DEBOUNCE_CYCLES %0d must be >= 2", DEBOUNCE_CYCLES);
  end

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] w_sync_q;
  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] r_edgecap;
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] w_clear;
  logic             w_wr;
  logic             w_unused_wdata;

  // Metastability chain: r_sync[0] samples the pins, last stage is the usable value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
    end
  end

  assign w_sync_q = r_sync[SYNC_STAGES-1];

`ifdef SWITCHES_IN_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CNT_W-1:0] r_tick_cnt;
  logic             w_tick;
  logic [WIDTH-1:0] r_samp;
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] w_agree;

  assign w_tick  = (r_tick_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign w_agree = ~(w_sync_q ^ r_samp);

  // A bit only moves once two consecutive ticks have seen the same level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick_cnt <= '0;
      r_samp     <= '0;
      r_stable   <= '0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + CNT_W'(1);
      if (w_tick) begin
        r_samp   <= w_sync_q;
        r_stable <= (w_sync_q & w_agree) | (r_stable & ~w_agree);
      end
    end
  end

  assign w_stable = r_stable;
`else
  assign w_stable = w_sync_q;
`endif

  always_comb begin
    w_edge = '0;
    if (EDGE_TYPE == 0) begin
      w_edge = w_stable & ~r_prev;
    end else if (EDGE_TYPE == 1) begin
      w_edge = ~w_stable & r_prev;
    end else begin
      w_edge = w_stable ^ r_prev;
    end
  end

  assign w_wr           = chipselect & ~write_n;
  assign w_clear        = (w_wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
  assign w_unused_wdata = &{1'b0, writedata};

  // New edges are OR-ed in after the clear so a coincident edge is never lost
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev    <= '0;
      r_edgecap <= '0;
      r_irqmask <= '0;
    end else begin
      r_prev    <= w_stable;
      r_edgecap <= (r_edgecap & ~w_clear) | w_edge;
      if (w_wr && address == ADDR_IRQMASK) begin
        r_irqmask <= writedata[WIDTH-1:0];
      end
    end
  end

  assign irq = |(r_edgecap & r_irqmask);

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata = 32'(w_stable);
      ADDR_IRQMASK: readdata = 32'(r_irqmask);
      ADDR_EDGECAP: readdata = 32'(r_edgecap);
      default:      readdata = '0;
    endcase
  end

endmodule
